// File: rtl/mmu_bus_arbiter_pkg.sv
// rtl/mmu_bus_arbiter_pkg.sv - mmu bus transfer encodings and arbiter state type
package mmu_pkg;

    localparam logic [2:0] TRANSFER_IDLE   = 3'b000;
    localparam logic [2:0] TRANSFER_NONSEQ = 3'b010;
    localparam logic [2:0] TRANSFER_SEQ    = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_NONSEQ = 2'd1,
        ST_SEQ    = 2'd2,
        ST_ERR    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mmu_bus_arbiter_if.sv
// rtl/mmu_bus_arbiter_if.sv - driver claim / unit handshake bundle around the arbiter
interface mmu_bus_arbiter_if #(
    parameter int DRIVER_CNT = 2
);
    localparam int IDX_W = (DRIVER_CNT > 1) ? $clog2(DRIVER_CNT) : 1;

    logic [DRIVER_CNT-1:0] CLAIM;
    logic                  U_READYOUT;
    logic                  U_RESP;
    logic [2:0]            TRANS;
    logic [DRIVER_CNT-1:0] GRANT;
    logic [IDX_W-1:0]      GRANT_IDX;
    logic [DRIVER_CNT-1:0] D_READYOUT;
    logic [DRIVER_CNT-1:0] D_RESP;
    logic                  ABORT;

    modport master (
        input  CLAIM, U_READYOUT, U_RESP,
        output TRANS, GRANT, GRANT_IDX, D_READYOUT, D_RESP, ABORT
    );

    modport slave (
        output CLAIM, U_READYOUT, U_RESP,
        input  TRANS, GRANT, GRANT_IDX, D_READYOUT, D_RESP, ABORT
    );

endinterface

// File: rtl/mmu_bus_arbiter_rr_pick.sv
// rtl/mmu_bus_arbiter_rr_pick.sv - first request after a pointer, wrapping, with optional exclusion
module mmu_rr_pick #(
    parameter int DRIVER_CNT = 2,
    parameter int IDX_W      = 1
) (
    input  logic [DRIVER_CNT-1:0] req,
    input  logic [IDX_W-1:0]      ptr,
    input  logic [DRIVER_CNT-1:0] exclude,
    output logic [DRIVER_CNT-1:0] onehot,
    output logic [IDX_W-1:0]      idx,
    output logic                  valid
);

    logic [DRIVER_CNT-1:0] req_m;

    assign req_m = req & ~exclude;

    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        // ptr itself is checked last, so the previous winner has lowest priority
        for (int k = 1; k <= DRIVER_CNT; k++) begin
            j = int'(ptr) + k;
            if (j >= DRIVER_CNT) begin
                j = j - DRIVER_CNT;
            end
            if (!valid && req_m[j]) begin
                valid     = 1'b1;
                onehot[j] = 1'b1;
                idx       = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mmu_bus_arbiter.sv
// rtl/mmu_bus_arbiter.sv - round-robin owner selection and TRANS sequencing for the mmu_unit bus
module mmu_bus_arbiter
    import mmu_pkg::*;
#(
    parameter int DRIVER_CNT = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                CLK,
    input  logic                RST,
    mmu_bus_arbiter_if.master   bus
);

    localparam int IDX_W = (DRIVER_CNT > 1) ? $clog2(DRIVER_CNT) : 1;
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [2:0]            trans_q, trans_d;
    logic [DRIVER_CNT-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
    logic [DRIVER_CNT-1:0] d_ready_q, d_ready_d;
    logic [DRIVER_CNT-1:0] d_resp_q, d_resp_d;
    logic                  abort_q, abort_d;

    logic [DRIVER_CNT-1:0] excl;
    logic [DRIVER_CNT-1:0] pick_oh;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;

    // the owner only loses its place when someone else is waiting
    assign excl = ((bus.CLAIM & ~grant_q) != '0) ? grant_q : '0;

    mmu_rr_pick #(
        .DRIVER_CNT (DRIVER_CNT),
        .IDX_W      (IDX_W)
    ) u_pick (
        .req     (bus.CLAIM),
        .ptr     (ptr_q),
        .exclude (excl),
        .onehot  (pick_oh),
        .idx     (pick_idx),
        .valid   (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        timer_d     = timer_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        abort_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid && bus.U_READYOUT && !bus.U_RESP) begin
                    grant_d     = pick_oh;
                    grant_idx_d = pick_idx;
                    ptr_d       = pick_idx;
                    state_d     = ST_NONSEQ;
                end
            end
            ST_NONSEQ: begin
                timer_d = '0;
                state_d = ST_SEQ;
            end
            ST_SEQ: begin
                if (bus.U_RESP) begin
                    state_d = ST_ERR;
                end else if (bus.U_READYOUT) begin
                    if (pick_valid) begin
                        grant_d     = pick_oh;
                        grant_idx_d = pick_idx;
                        ptr_d       = pick_idx;
                        state_d     = ST_NONSEQ;
                    end else begin
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    abort_d = 1'b1;
                    state_d = ST_ERR;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_ERR: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // outputs are precomputed from the next state so every port comes straight off a flop
    always_comb begin
        trans_d   = TRANSFER_IDLE;
        d_ready_d = '1;
        d_resp_d  = '0;
        case (state_d)
            ST_NONSEQ, ST_SEQ: begin
                trans_d   = (state_d == ST_NONSEQ) ? TRANSFER_NONSEQ : TRANSFER_SEQ;
                d_ready_d = bus.U_READYOUT ? '1 : ~grant_d;
                d_resp_d  = bus.U_RESP ? grant_d : '0;
            end
            ST_ERR: begin
                d_resp_d = grant_d;
            end
            default: begin
                trans_d = TRANSFER_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            ptr_q       <= IDX_W'(DRIVER_CNT - 1);
            timer_q     <= '0;
            trans_q     <= TRANSFER_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            d_ready_q   <= '1;
            d_resp_q    <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            timer_q     <= timer_d;
            trans_q     <= trans_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            d_ready_q   <= d_ready_d;
            d_resp_q    <= d_resp_d;
            abort_q     <= abort_d;
        end
    end

    assign bus.TRANS      = trans_q;
    assign bus.GRANT      = grant_q;
    assign bus.GRANT_IDX  = grant_idx_q;
    assign bus.D_READYOUT = d_ready_q;
    assign bus.D_RESP     = d_resp_q;
    assign bus.ABORT      = abort_q;

endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// tb/tb_mmu_bus_arbiter.sv - directed and randomized checks of mmu_bus_arbiter against a burst-level model
module tb_mmu_bus_arbiter;

    localparam int N  = 3;
    localparam int TO = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    mmu_bus_arbiter_if #(.DRIVER_CNT(N)) bus ();

    mmu_bus_arbiter #(.DRIVER_CNT(N), .TIMEOUT(TO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // burst-level model: phase 0 idle, 1 address beat, 2 data beats, 3 error beat
    int  m_phase = 0;
    int  m_owner = -1;
    int  m_last  = N - 1;
    int  m_age   = 0;
    bit  m_valid = 0;
    logic [2:0]   exp_trans;
    logic [N-1:0] exp_grant, exp_ready, exp_resp;
    logic         exp_abort;

    function automatic int rr(input logic [N-1:0] c, input int last, input int own);
        bit others;
        others = 0;
        for (int i = 0; i < N; i++) begin
            if (c[i] && i != own && own >= 0) others = 1;
        end
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (c[j] && !(others && j == own)) return j;
        end
        return -1;
    endfunction

    always @(posedge CLK) begin
        logic [N-1:0] oh;
        exp_abort = 1'b0;
        if (RST) begin
            m_phase = 0; m_owner = -1; m_last = N - 1; m_age = 0;
            m_valid = 1;
        end else begin
            case (m_phase)
                0: if (bus.CLAIM != 0 && bus.U_READYOUT && !bus.U_RESP) begin
                       m_owner = rr(bus.CLAIM, m_last, -1);
                       m_last  = m_owner;
                       m_phase = 1;
                   end
                1: begin m_phase = 2; m_age = 0; end
                2: begin
                       if (bus.U_RESP) m_phase = 3;
                       else if (bus.U_READYOUT) begin
                           if (bus.CLAIM != 0) begin
                               m_owner = rr(bus.CLAIM, m_last, m_owner);
                               m_last  = m_owner;
                               m_phase = 1;
                           end else begin
                               m_owner = -1;
                               m_phase = 0;
                           end
                       end else if (m_age == TO - 1) begin
                           exp_abort = 1'b1;
                           m_phase   = 3;
                       end else m_age++;
                   end
                default: begin m_owner = -1; m_phase = 0; end
            endcase
        end
        oh = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        exp_grant = oh;
        exp_trans = (m_phase == 1) ? 3'b010 : (m_phase == 2) ? 3'b011 : 3'b000;
        exp_ready = '1;
        exp_resp  = '0;
        if (m_phase == 3) exp_resp = oh;
        else if (m_phase == 1 || m_phase == 2) begin
            exp_ready = bus.U_READYOUT ? '1 : ~oh;
            exp_resp  = bus.U_RESP ? oh : '0;
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("trans", 32'(bus.TRANS), 32'(exp_trans));
            chk("grant", 32'(bus.GRANT), 32'(exp_grant));
            chk("abort", 32'(bus.ABORT), 32'(exp_abort));
            chk("d_readyout", 32'(bus.D_READYOUT), 32'(exp_ready));
            chk("d_resp", 32'(bus.D_RESP), 32'(exp_resp));
            if (exp_grant != 0) chk("grant_idx", 32'(bus.GRANT_IDX), 32'(m_owner));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_grant"}, 32'(bus.GRANT), 32'h0);
        chk({tag, "_idx"}, 32'(bus.GRANT_IDX), 32'h0);
        chk({tag, "_trans"}, 32'(bus.TRANS), 32'h0);
        chk({tag, "_abort"}, 32'(bus.ABORT), 32'h0);
        chk({tag, "_resp"}, 32'(bus.D_RESP), 32'h0);
        chk({tag, "_ready"}, 32'(bus.D_READYOUT), 32'h7);
    endtask

    initial begin
        int grants[$];
        int idle_n, seq_n, stall_left;
        bit got_abort;

        bus.CLAIM = '0; bus.U_READYOUT = 1'b1; bus.U_RESP = 1'b0;
        do_reset();
        chk_reset_vals("rst");

        // single burst with a one-cycle data stall
        bus.CLAIM = 3'b001;
        tick();
        chk("t1_grant", 32'(bus.GRANT), 32'h1);
        chk("t1_nonseq", 32'(bus.TRANS), 32'h2);
        bus.CLAIM = '0; bus.U_READYOUT = 1'b0;
        tick();
        tick();
        chk("t1_seq", 32'(bus.TRANS), 32'h3);
        bus.U_READYOUT = 1'b1;
        tick();
        chk("t1_release", 32'(bus.GRANT), 32'h0);
        chk("t1_idle", 32'(bus.TRANS), 32'h0);

        // back-to-back alternation
        do_reset();
        bus.CLAIM = 3'b011; bus.U_READYOUT = 1'b1;
        idle_n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.TRANS == 3'b010) grants.push_back(int'(bus.GRANT));
            if (bus.TRANS == 3'b000) idle_n++;
        end
        chk("t2_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < grants.size() && i < 4; i++)
            chk("t2_order", 32'(grants[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
        chk("t2_gap", 32'(idle_n), 32'd0);
        bus.CLAIM = '0;
        tick();
        tick();

        // owner drops claim mid-burst
        do_reset();
        bus.CLAIM = 3'b001; bus.U_READYOUT = 1'b1;
        tick();
        bus.U_READYOUT = 1'b0;
        tick();
        bus.CLAIM = '0;
        tick();
        chk("t3_hold", 32'(bus.GRANT), 32'h1);
        bus.U_READYOUT = 1'b1;
        tick();
        chk("t3_release", 32'(bus.GRANT), 32'h0);

        // error response
        do_reset();
        bus.CLAIM = 3'b011; bus.U_READYOUT = 1'b1;
        tick();
        bus.U_READYOUT = 1'b0;
        tick();
        bus.U_RESP = 1'b1;
        tick();
        chk("t4_resp", 32'(bus.D_RESP), 32'h1);
        chk("t4_trans", 32'(bus.TRANS), 32'h0);
        bus.U_RESP = 1'b0; bus.U_READYOUT = 1'b1;
        tick();
        chk("t4_drop", 32'(bus.GRANT), 32'h0);
        chk("t4_resp_clr", 32'(bus.D_RESP), 32'h0);
        tick();
        chk("t4_next", 32'(bus.GRANT), 32'h2);
        bus.CLAIM = '0;
        tick();
        tick();
        tick();

        // timeout abort
        do_reset();
        bus.CLAIM = 3'b001; bus.U_READYOUT = 1'b1;
        tick();
        bus.U_READYOUT = 1'b0; bus.CLAIM = '0;
        seq_n = 0; got_abort = 0;
        for (int i = 0; i < 20 && !got_abort; i++) begin
            tick();
            if (bus.TRANS == 3'b011) seq_n++;
            if (bus.ABORT) got_abort = 1;
        end
        chk("t5_abort", 32'(got_abort), 32'h1);
        chk("t5_seq_cycles", 32'(seq_n), 32'd8);
        chk("t5_resp", 32'(bus.D_RESP), 32'h1);
        bus.U_READYOUT = 1'b1;
        tick();
        chk("t5_idle", 32'(bus.GRANT), 32'h0);
        chk("t5_pulse", 32'(bus.ABORT), 32'h0);

        // reset mid-burst
        bus.CLAIM = 3'b011;
        tick();
        bus.U_READYOUT = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        tick();
        chk_reset_vals("t6");
        RST = 1'b0; bus.U_READYOUT = 1'b1;
        tick();
        chk("t6_first", 32'(bus.GRANT), 32'h1);

        // randomized traffic against the model
        stall_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (stall_left > 0) begin
                bus.U_READYOUT = 1'b0;
                stall_left--;
            end else begin
                bus.U_READYOUT = ($urandom_range(0, 9) < 6);
                if ($urandom_range(0, 39) == 0) stall_left = 12;
            end
            bus.U_RESP = ($urandom_range(0, 29) == 0);
            bus.CLAIM  = N'($urandom_range(0, 7));
            RST        = ($urandom_range(0, 299) == 0);
            tick();
        end
        RST = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
